// File: rtl/pulse_width_capture.sv
// pulse_width_capture: measures din high time in clk cycles, saturating at 2^W-1,
// and hands the result out through a valid/ack handshake.
module pulse_width_capture #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         din,
   input  logic         ack,
   output logic [W-1:0] width,
   output logic         valid,
   output logic         ovf,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;
   localparam logic [W-1:0] MAX = '1;
   state_t       state, state_nxt;
   logic [W-1:0] count, count_nxt, width_nxt;
   logic         sat, sat_nxt, valid_nxt, ovf_nxt;
   logic         s1, s2, s3, rise;
   logic [1:0]   prime;
   // s3 is pinned high until s2 carries real din samples, so a pulse already high at reset release never looks like a rise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b1;
         prime <= 2'b00;
      end else begin
         s1    <= din;
         s2    <= s1;
         s3    <= prime[1] ? s2 : 1'b1;
         prime <= {prime[0], 1'b1};
      end
   end
   assign rise = s2 & ~s3;
   assign busy = state == MEASURE;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
         sat   <= 1'b0;
         width <= '0;
         ovf   <= 1'b0;
         valid <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         sat   <= sat_nxt;
         width <= width_nxt;
         ovf   <= ovf_nxt;
         valid <= valid_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      sat_nxt   = sat;
      width_nxt = width;
      ovf_nxt   = ovf;
      valid_nxt = valid;
      case (state)
         IDLE: if (rise) begin
            count_nxt = W'(1);
            sat_nxt   = 1'b0;
            state_nxt = MEASURE;
         end
         MEASURE: if (s2) begin
            count_nxt = (count == MAX) ? count : count + 1'b1;
            sat_nxt   = sat | (count == MAX);
         end else begin
            width_nxt = count;
            ovf_nxt   = sat;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: if (ack) begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: doc/pulse_width_capture.md
Name: pulse_width_capture

Overview:
Measures the high time of an asynchronous input pulse in clk cycles and presents the result as a W-bit word with a valid/ack handshake. It is the measuring counterpart of the 6-bit compare timer: the timer produces a delay of C cycles, and this block recovers such a count from a pulse on a wire. The block sits beside the timer in the same clock domain, for self-test loopback and for measuring external strobes.

Parameters:
W, 6, counter and result width in bits; maximum measurable count is 2^W-1.

Ports:
clk    input   1  system clock; all state updates on the rising edge.
reset  input   1  asynchronous, active-low reset; asserting it (0) forces all state to reset values immediately.
din    input   1  asynchronous pulse input to be measured.
ack    input   1  consumer acknowledge; sampled only in state HOLD.
width  output  W  captured high-time in clk cycles, saturated at 2^W-1.
valid  output  1  width/ovf hold a fresh, unacknowledged result.
ovf    output  1  captured pulse was high for 2^W or more cycles; qualified by valid.
busy   output  1  a pulse is currently being measured (state MEASURE).

Behaviour:
- Reset, asynchronous, active-low:
  - state=IDLE, count=0, width=0, valid=0, ovf=0, busy=0.
  - Synchronizer flops s1=0, s2=0.
  - Edge-history flop s3=1, so a pulse already high at reset release is not measured.
- Synchronizer: din -> s1 -> s2 (2 flops); s3 <= s2. Rise = s2 & ~s3. All decisions use s2 only.
- count is a W-bit register. Internal flag sat is set when an increment is attempted at count=2^W-1.
- IDLE:
  - busy=0.
  - On rise: count<=1, sat<=0, go to MEASURE.
  - Otherwise hold.
- MEASURE:
  - busy=1.
  - While s2=1: if count<2^W-1, count<=count+1; else count holds at 2^W-1 and sat<=1.
  - When s2=0: width<=count, ovf<=sat, valid<=1, go to HOLD.
  - Result: width equals the number of rising clk edges at which din was sampled high, saturated.
- HOLD:
  - busy=0. valid, width and ovf stay stable.
  - New pulses are ignored and not queued.
  - On ack=1: valid<=0, go to IDLE. width and ovf keep their last values.
  - A pulse whose rise occurs while in HOLD is never measured. Its s2 is already high on return to IDLE, so no rise is seen.
- ack in IDLE or MEASURE: no effect.
- ack held high continuously: each result is valid for exactly 1 cycle.
- Latency:
  - din first sampled high at edge k -> busy=1 after edge k+2.
  - din first sampled low at edge m -> valid=1 after edge m+2.
  - valid -> valid=0: 1 cycle after ack is sampled high.
- Minimum pulse: 1 sampled-high cycle gives width=1. Glitches not sampled by clk are not seen.
- Wrap-around: none. The counter saturates and never rolls over to 0.
- Reset mid-MEASURE or mid-HOLD: the result is lost, all outputs return to reset values, and the current din pulse is not measured.
- Fully synchronous except reset. No gated or derived clocks.

Test Plan:
1. Reset released with din=0; din high for 5 cycles then low -> valid=1 two edges after first low sample, width=5, ovf=0, busy high for 5 cycles; ack 1 cycle -> valid=0 next edge.
2. din high 63 cycles -> width=63, ovf=0. din high 64 cycles -> width=63, ovf=1. din high 100 cycles -> width=63, ovf=1, no wrap to small values.
3. din high 1 cycle -> width=1. Then 3-cycle pulse while valid=1 and ack=0 -> ignored; ack -> IDLE, width stays 1, no second valid.
4. din held high through reset release -> no busy, no valid; din falls then rises for 7 cycles -> width=7.
5. ack tied 1, back-to-back pulses of 4, 9, 2 cycles separated by 3 low cycles -> three 1-cycle valid pulses with width 4, 9, 2.
6. reset asserted at cycle 10 of a 20-cycle pulse -> outputs 0 immediately (asynchronously); after release, no capture of the remainder of that pulse.
